// File: rtl/uart_txfifo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_txfifo_pkg
// Brief   : Shared types and constants for the UART transmit FIFO.
// Revision: 1.0
// ============================================================================
package uart_txfifo_pkg;

    localparam int DEFAULT_DEPTH_LOG2 = 4;
    localparam int FIFO_DEPTH         = 1 << DEFAULT_DEPTH_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } drain_state_t;

    function automatic int fifo_depth(input int depth_log2);
        return 1 << depth_log2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_txfifo_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_txfifo_if
// Brief   : Host write handshake plus transmitter drain signals.
// Revision: 1.0
// ============================================================================
interface uart_txfifo_if
    import uart_txfifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
);
    logic                  wr_valid;
    logic [7:0]            wr_data;
    logic                  wr_ready;
    logic                  load;
    logic [7:0]            d;
    logic                  txbusy;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;

    // master is the host/transmitter side, slave is the FIFO
    modport master (
        output wr_valid, wr_data, txbusy,
        input  wr_ready, load, d, count, overflow
    );

    modport slave (
        input  wr_valid, wr_data, txbusy,
        output wr_ready, load, d, count, overflow
    );
endinterface
`default_nettype wire

// File: rtl/uart_txfifo_ram.sv
`default_nettype none
// ============================================================================
// Module  : uart_fifo_ram_m
// Brief   : Simple dual-port byte memory, synchronous write, async read.
// Revision: 1.0
// ============================================================================
module uart_fifo_ram_m #(
    parameter int ADDR_W = 4
) (
    input  wire logic              clk,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_waddr,
    input  wire logic [7:0]        i_wdata,
    input  wire logic [ADDR_W-1:0] i_raddr,
    output logic      [7:0]        o_rdata
);
    localparam int c_words = 1 << ADDR_W;

    // Contents are intentionally not reset; the pointer logic never reads an
    // entry that has not been written since reset.
    logic [7:0] r_mem [c_words];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/uart_txfifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_txfifo
// Brief   : Byte FIFO feeding the UART transmitter load/d inputs.
// Revision: 1.0
// ============================================================================
module uart_txfifo
    import uart_txfifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    uart_txfifo_if.slave  bus
);
    localparam int                  c_depth = fifo_depth(DEPTH_LOG2);
    localparam logic [DEPTH_LOG2:0] c_full  = c_depth[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0] c_one   = {{DEPTH_LOG2{1'b0}}, 1'b1};

    drain_state_t          r_state;
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [DEPTH_LOG2:0]   w_count_next;
    logic                  r_wr_ready;
    logic                  r_overflow;
    logic                  r_load;
    logic [7:0]            r_d;
    logic [7:0]            w_rd_data;
    logic                  w_push;
    logic                  w_pop;

    // A full FIFO has wr_ready low, so a same-cycle pop never frees a slot
    assign w_push = bus.wr_valid & r_wr_ready;
    assign w_pop  = (r_state == ST_IDLE) && (r_count != '0) && !bus.txbusy;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + c_one;
            2'b01:   w_count_next = r_count - c_one;
            default: w_count_next = r_count;
        endcase
    end

    uart_fifo_ram_m #(
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.wr_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wr_ready <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count    <= w_count_next;
            r_wr_ready <= (w_count_next != c_full);
            r_overflow <= r_overflow | (bus.wr_valid & ~r_wr_ready);
        end
    end

    // HOLD covers the edge on which the transmitter has not yet raised txbusy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_load  <= 1'b0;
            r_d     <= 8'h00;
        end else begin
            r_load <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_state <= ST_LOAD;
                        r_load  <= 1'b1;
                        r_d     <= w_rd_data;
                    end
                end
                ST_LOAD: r_state <= ST_HOLD;
                ST_HOLD: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.wr_ready = r_wr_ready;
    assign bus.load     = r_load;
    assign bus.d        = r_d;
    assign bus.count    = r_count;
    assign bus.overflow = r_overflow;

endmodule
`default_nettype wire

// File: doc/uart_txfifo.md
# uart_txfifo

Transmit-side byte buffer that sits directly upstream of the UART transmitter. It accepts bytes from the host over a valid/ready handshake and stores them in a FIFO of 2^DEPTH_LOG2 entries. It drains the FIFO into the transmitter's `load`/`d` inputs, one byte per frame, gated by `txbusy`. It lets firmware burst a message without polling `txbusy` per byte.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 bytes; legal range 1..9.
- `clk` in 1: system clock, the same clock as the transmitter.
- `rst_n` in 1: one clock; reset is synchronous and active-low.
- `wr_valid` in 1: host offers `wr_data` this cycle.
- `wr_data` in 8: byte to enqueue.
- `wr_ready` out 1: registered; the FIFO can accept a byte this cycle.
- `load` out 1: registered; one-cycle strobe to the transmitter `load`.
- `d` out 8: registered; byte to the transmitter `d`; valid whenever `load`=1.
- `txbusy` in 1: transmitter status; a high level forbids `load`.
- `count` out DEPTH_LOG2+1: registered; number of bytes currently stored.
- `overflow` out 1: sticky; set when `wr_valid`=1 while `wr_ready`=0.

## Operation
- Push: a byte is accepted when `wr_valid` and `wr_ready` are both high at a rising edge; it is written at the write pointer, and the write pointer increments modulo depth.
- Pop: occurs on the same edge that sets `load`=1; `d` takes the head byte and the read pointer increments modulo depth.
- `count` tracks push minus pop:
  - Simultaneous push and pop leaves `count` unchanged.
  - `count` never exceeds 2^DEPTH_LOG2 and never goes below 0.
- `wr_ready` next value is `count_next` != 2^DEPTH_LOG2.
  - Full: a write is refused even if a pop happens in the same cycle. There is no pass-through when full.
  - Empty: `count`=0; no `load` is issued.
- Drain state machine, 3 states:
  - IDLE: if `count`≠0 and `txbusy`=0, go to LOAD. On that edge set `load`=1 and pop.
  - LOAD: `load`=1 for exactly this cycle. Always go to HOLD.
  - HOLD: `txbusy` is ignored, because the transmitter raises it only on the edge after `load`. Always go to IDLE.
- `d` holds its last value between loads; it is never updated except on a pop.
- `overflow` is set on any cycle with `wr_valid`=1 and `wr_ready`=0. It is cleared only by reset. The refused byte is dropped.
- Reset (`rst_n`=0 at an edge), values after that edge:
  - Pointers and `count` are 0.
  - State is IDLE.
  - `load`=0, `d`=8'h00, `wr_ready`=0, `overflow`=0.
  - `wr_ready` rises on the first edge with `rst_n`=1.
  - Reset mid-frame discards queued bytes and does not interrupt the transmitter's current frame.
- Memory contents are not reset; the design must never read an unwritten entry.

## Timing
- Write latency: a byte accepted at edge k into an empty FIFO with `txbusy`=0 gives `load`=1 in the cycle after edge k+1.
- Minimum `load` spacing is 3 cycles (LOAD, HOLD, IDLE evaluation). Actual spacing is set by `txbusy`, which spans a full frame.
- `count` and `wr_ready` reflect a push one edge after it is accepted. `wr_ready` deasserts on the edge that makes the FIFO full.
- Simultaneous push and pop on the same edge with `count`=1: after the edge, `count`=1 and `d` holds the old head.
- Pointer wrap: after 2^DEPTH_LOG2 pushes the write pointer returns to 0. No bubble or lost byte is allowed at the wrap.

## Structure
- Shared package/include holds:
  - the drain state encodings IDLE/LOAD/HOLD;
  - the constant FIFO_DEPTH = 1<<DEPTH_LOG2.
- One sub-module is natural: `uart_fifo_ram_m`, a simple dual-port 8-bit memory with a synchronous write and a read usable on the pop edge. It maps to distributed LUT RAM for depth ≤16 and to block RAM above that.
- Pointer, count and state logic live in the top module.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles, then release. Required: `wr_ready`=0 during reset and 1 one cycle after release; `count`=0, `load`=0, `d`=8'h00, `overflow`=0.
- Single byte: `txbusy`=0; push 8'hA5 at edge k. Required: `load`=1 with `d`=8'hA5 exactly one cycle after edge k+1; `count` returns to 0; no second `load`.
- Ordered burst: push 8'h01..8'h05 back-to-back while a bench transmitter model holds `txbusy` high for 100 cycles after each `load`. Required: five loads carrying 01..05 in order, each `load` at least 1 cycle after `txbusy` falls.
- Full and overflow (DEPTH_LOG2=4): `txbusy` held high; push 17 bytes. Required: `count`=16, `wr_ready`=0 after the 16th push, the 17th byte refused, `overflow`=1. Releasing `txbusy` then drains all 16 bytes in order.
- Wrap-around: push and drain 40 bytes (values 0..39) through a 16-entry FIFO. Required: output sequence identical to input, with no duplicated or skipped value at pointer wrap.
- Reset mid-operation: with 6 bytes queued and `load` just issued, assert `rst_n`=0 for 1 cycle. Required: `count`=0, no further `load`; a new push of 8'h3C is the next byte loaded.
